mersenne_candidate_gen: RTL and testbench
=========================================

// Module: mersenne_candidate_gen
// PURPOSE
//  Upstream feeder for the mersenneFactoring checker. For a given exponent p, it walks k = 1..k_max
//  and forms trial divisors d = 2kp+1. Candidates with d mod 8 not in {1,7} are rejected.
//  Each surviving d is issued to the checker, and the block waits for its verdict.
//  The walk stops on the first factor, on k_max, or on 32-bit divisor overflow.
// PARAMETERS
//  DW    32  width of p, d, factor (checker operand width)
//  KW    32  width of k counter, k_max, k_out
// PORTS
//  sys_clk        in   1   system clock
//  sys_rst        in   1   synchronous reset, active-high
//  start          in   1   1-cycle pulse: latch p, k_max, begin search
//  p              in   DW  Mersenne exponent (must be >= 3)
//  k_max          in   KW  last k to try (inclusive)
//  busy           out  1   high from accepted start until done
//  done           out  1   1-cycle pulse at end of search
//  found          out  1   held: last search found a factor
//  err            out  1   held: last search ended on bad p or d overflow
//  factor         out  DW  held: factor found (0 if none)
//  k_out          out  KW  held: k of factor, or last k examined
//  chk_start      out  1   1-cycle pulse to checker .start
//  chk_p          out  DW  to checker .p; stable from chk_start until chk_finished
//  chk_d          out  DW  to checker .d; stable from chk_start until chk_finished
//  chk_isPrime    in   1   from checker .isPrime: 1 = d does not divide 2^p-1, 0 = d is a factor
//  chk_finished   in   1   from checker .finished; valid verdict when high
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, found, err, chk_start = 0; factor, k_out, chk_p, chk_d = 0.
//  FSM states:
//   IDLE  : start -> INIT.
//   INIT  : bad p (p<3 or even) -> DONE with err=1.
//           Otherwise d=2p+1, k=1, inc=2p (DW+1 bits), r8=d mod 8; -> GEN.
//   GEN   : if k > k_max -> DONE (found=0).
//           Else if filter passes -> ISSUE.
//           Else advance, stay in GEN (one candidate per cycle).
//   ISSUE : chk_start=1 for exactly this cycle; chk_d=d; -> WAIT.
//   WAIT  : chk_finished is ignored in the ISSUE cycle. On first chk_finished=1 after ISSUE:
//           chk_isPrime=0 -> found=1, factor=d, k_out=k -> DONE.
//           chk_isPrime=1 -> advance -> GEN.
//   DONE  : done=1 for one cycle, busy=0 -> IDLE.
//  Advance: k+=1, d+=inc computed in DW+1 bits.
//   Carry out -> DONE with err=1, found=0, k_out = last k examined.
//   r8 is updated incrementally: r8 = (r8 + inc[2:0]) & 7. No divider and no multiplier.
//  Filter: r8==1 or r8==7.
//  start while busy: ignored. start in the same cycle as DONE: ignored; accepted from IDLE.
//  k_max=0: DONE on first GEN cycle, found=0, err=0, no checker issue.
//  sys_rst mid-search (any state, including WAIT): immediate return to reset values.
//   A checker verdict arriving after reset is ignored; the checker shares sys_rst via top.
//  busy=1 in INIT, GEN, ISSUE, WAIT.
//  found, err, factor and k_out are cleared on accepted start and held after DONE.
// CONFIGURATION
//  SMALL_PRIME_SIEVE_EN defined:
//   - Extra residue registers r3, r5, r7 (d mod 3/5/7), updated incrementally like r8
//     using inc mod 3/5/7, which INIT computes by repeated subtraction over <=DW cycles.
//   - The filter additionally rejects d with a zero residue unless d equals 3, 5 or 7.
//   - INIT latency grows to <=DW+1 cycles.
//  SMALL_PRIME_SIEVE_EN undefined: mod-8 filter only; INIT is 1 cycle; no residue logic.
// TESTING (bench uses a behavioural checker model answering 3 cycles after chk_start)
//  p=11, k_max=10 -> one issue, d=23; found=1, factor=23, k_out=1.
//  p=29, k_max=10 -> k=1 (59) and k=2 (117) rejected in GEN.
//   - Sieve off: 175 issued (not factor), then 233; found=1, factor=233, k_out=4.
//   - Sieve on: 175 also rejected; only 233 is issued.
//  p=13, k_max=100 -> done after k=100 with found=0, err=0, factor=0, k_out=100.
//   - Verify every issued d has d mod 8 in {1,7}.
//  p=2147483647, k_max=5 -> d=4294967295 issued; model answers not-factor.
//   - Next advance overflows: err=1, found=0, k_out=1.
//  p=4 -> done 2 cycles after start with err=1, no chk_start.
//   - Also: start pulsed while busy is ignored.
//  Assert sys_rst in WAIT, release, restart with p=23:
//   - All outputs return to reset values immediately.
//   - Clean search: factor=47, k_out=1.

Source files
------------

// File: rtl/mersenne_candidate_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : mersenne_candidate_gen_if
//  Brief    : Host control/status bundle plus the checker handshake used by
//             the Mersenne trial-divisor candidate generator.
//  Revision : 1.0 - initial release
// ============================================================================
interface mersenne_candidate_gen_if #(
  parameter int DW = 32,
  parameter int KW = 32
);
  // host side: search request and held result
  logic          start;
  logic [DW-1:0] p;
  logic [KW-1:0] k_max;
  logic          busy;
  logic          done;
  logic          found;
  logic          err;
  logic [DW-1:0] factor;
  logic [KW-1:0] k_out;

  // checker side: one divisor at a time, verdict comes back later
  logic          chk_start;
  logic [DW-1:0] chk_p;
  logic [DW-1:0] chk_d;
  logic          chk_isPrime;
  logic          chk_finished;

  // the generator itself
  modport slave (
    input  start, p, k_max, chk_isPrime, chk_finished,
    output busy, done, found, err, factor, k_out, chk_start, chk_p, chk_d
  );

  // host plus checker surrounding the generator
  modport master (
    output start, p, k_max, chk_isPrime, chk_finished,
    input  busy, done, found, err, factor, k_out, chk_start, chk_p, chk_d
  );
endinterface
`default_nettype wire

// File: rtl/mersenne_candidate_gen.sv
`default_nettype none
// ============================================================================
//  Module   : mersenne_candidate_gen
//  Brief    : Walks k = 1..k_max for exponent p, forms d = 2kp+1, drops
//             candidates with d mod 8 outside {1,7}, issues survivors to the
//             Mersenne factor checker and stops on the first factor, on k_max
//             or on divisor overflow. All residues are tracked incrementally.
//  Options  : SMALL_PRIME_SIEVE_EN - also drop d divisible by 3, 5 or 7
//             (except d itself equal to 3, 5 or 7); INIT then takes DW cycles
//             to reduce p bit-serially.
//  Revision : 1.0 - initial release
// ============================================================================
module mersenne_candidate_gen #(
  parameter int DW = 32,
  parameter int KW = 32
) (
  input  wire logic                   sys_clk,
  input  wire logic                   sys_rst,
  mersenne_candidate_gen_if.slave     bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_GEN   = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] chk_p_q, chk_p_d;     // latched exponent, also drives checker
  logic [KW-1:0] kmax_q, kmax_d;
  logic [KW:0]   k_q, k_d;             // one spare bit so k_max = all-ones terminates
  logic [DW-1:0] d_q, d_d;
  logic [DW:0]   inc_q, inc_d;         // 2p
  logic [2:0]    r8_q, r8_d;           // d mod 8
  logic          found_q, found_d;
  logic          err_q, err_d;
  logic [DW-1:0] factor_q, factor_d;
  logic [KW-1:0] k_out_q, k_out_d;
  logic [DW-1:0] chk_d_q, chk_d_d;

  logic [DW+1:0] w_sum;                // d + inc with room for any carry
  logic          w_ovf;
  logic          w_bad_p;
  logic          w_pass;
  logic          w_adv;

`ifdef SMALL_PRIME_SIEVE_EN
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  logic [DW-1:0] sh_q, sh_d;           // p shifted out MSB-first during INIT
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    pm3_q, pm3_d, pm5_q, pm5_d, pm7_q, pm7_d;   // p mod m, partial
  logic [2:0]    i3_q, i3_d, i5_q, i5_d, i7_q, i7_d;         // inc mod m
  logic [2:0]    r3_q, r3_d, r5_q, r5_d, r7_q, r7_d;         // d mod m
  logic          w_sieve_ok;

  // (2r + b) mod m for r < m: a single conditional subtraction
  function automatic logic [2:0] mod_shift(input logic [2:0] r, input logic b,
                                           input logic [2:0] m);
    logic [3:0] t;
    t = {r, 1'b0} + {3'b000, b};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    return t[2:0];
  endfunction

  // (a + b) mod m for a, b < m
  function automatic logic [2:0] mod_add(input logic [2:0] a, input logic [2:0] b,
                                         input logic [2:0] m);
    logic [3:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    return t[2:0];
  endfunction

  // a zero residue means a small prime divides d, unless d is that prime
  always_comb begin
    w_sieve_ok = !(((r3_q == 3'd0) && (d_q != DW'(3))) ||
                   ((r5_q == 3'd0) && (d_q != DW'(5))) ||
                   ((r7_q == 3'd0) && (d_q != DW'(7))));
  end
`endif

  // shared datapath terms: next divisor, overflow, exponent sanity, filter
  always_comb begin
    w_sum   = {2'b00, d_q} + {1'b0, inc_q};
    w_ovf   = |w_sum[DW+1:DW];
    w_bad_p = (chk_p_q < DW'(3)) || !chk_p_q[0];
`ifdef SMALL_PRIME_SIEVE_EN
    w_pass  = ((r8_q == 3'd1) || (r8_q == 3'd7)) && w_sieve_ok;
`else
    w_pass  = (r8_q == 3'd1) || (r8_q == 3'd7);
`endif
  end

  // next-state and datapath updates for the search walk
  always_comb begin
    state_d  = state_q;
    chk_p_d  = chk_p_q;
    kmax_d   = kmax_q;
    k_d      = k_q;
    d_d      = d_q;
    inc_d    = inc_q;
    r8_d     = r8_q;
    found_d  = found_q;
    err_d    = err_q;
    factor_d = factor_q;
    k_out_d  = k_out_q;
    chk_d_d  = chk_d_q;
    w_adv    = 1'b0;
`ifdef SMALL_PRIME_SIEVE_EN
    sh_d  = sh_q;
    cnt_d = cnt_q;
    pm3_d = pm3_q;
    pm5_d = pm5_q;
    pm7_d = pm7_q;
    i3_d  = i3_q;
    i5_d  = i5_q;
    i7_d  = i7_q;
    r3_d  = r3_q;
    r5_d  = r5_q;
    r7_d  = r7_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          chk_p_d  = bus.p;
          kmax_d   = bus.k_max;
          found_d  = 1'b0;
          err_d    = 1'b0;
          factor_d = '0;
          k_out_d  = '0;
          state_d  = S_INIT;
`ifdef SMALL_PRIME_SIEVE_EN
          sh_d  = bus.p;
          cnt_d = '0;
          pm3_d = 3'd0;
          pm5_d = 3'd0;
          pm7_d = 3'd0;
`endif
        end
      end

      S_INIT: begin
        // p with its MSB set would make 2p+1 overflow the operand width
        if (w_bad_p || chk_p_q[DW-1]) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          d_d   = {chk_p_q[DW-2:0], 1'b1};
          inc_d = {chk_p_q, 1'b0};
          k_d   = (KW+1)'(1);
          r8_d  = {chk_p_q[1:0], 1'b1};
`ifdef SMALL_PRIME_SIEVE_EN
          sh_d  = {sh_q[DW-2:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
          pm3_d = mod_shift(pm3_q, sh_q[DW-1], 3'd3);
          pm5_d = mod_shift(pm5_q, sh_q[DW-1], 3'd5);
          pm7_d = mod_shift(pm7_q, sh_q[DW-1], 3'd7);
          if (cnt_q == CW'(DW - 1)) begin
            i3_d    = mod_add(pm3_d, pm3_d, 3'd3);
            i5_d    = mod_add(pm5_d, pm5_d, 3'd5);
            i7_d    = mod_add(pm7_d, pm7_d, 3'd7);
            r3_d    = mod_add(i3_d, 3'd1, 3'd3);
            r5_d    = mod_add(i5_d, 3'd1, 3'd5);
            r7_d    = mod_add(i7_d, 3'd1, 3'd7);
            state_d = S_GEN;
          end
`else
          state_d = S_GEN;
`endif
        end
      end

      S_GEN: begin
        if (k_q > {1'b0, kmax_q}) begin
          k_out_d = k_q[KW-1:0] - KW'(1);
          state_d = S_DONE;
        end else if (w_pass) begin
          chk_d_d = d_q;
          state_d = S_ISSUE;
        end else begin
          w_adv = 1'b1;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus.chk_finished) begin
          if (!bus.chk_isPrime) begin
            found_d  = 1'b1;
            factor_d = d_q;
            k_out_d  = k_q[KW-1:0];
            state_d  = S_DONE;
          end else begin
            w_adv = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // step to the next k; a divisor that no longer fits ends the search
    if (w_adv) begin
      if (w_ovf) begin
        err_d   = 1'b1;
        k_out_d = k_q[KW-1:0];
        state_d = S_DONE;
      end else begin
        k_d     = k_q + (KW+1)'(1);
        d_d     = w_sum[DW-1:0];
        r8_d    = r8_q + inc_q[2:0];
`ifdef SMALL_PRIME_SIEVE_EN
        r3_d    = mod_add(r3_q, i3_q, 3'd3);
        r5_d    = mod_add(r5_q, i5_q, 3'd5);
        r7_d    = mod_add(r7_q, i7_q, 3'd7);
`endif
        state_d = S_GEN;
      end
    end
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      chk_p_q  <= '0;
      kmax_q   <= '0;
      k_q      <= '0;
      d_q      <= '0;
      inc_q    <= '0;
      r8_q     <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      factor_q <= '0;
      k_out_q  <= '0;
      chk_d_q  <= '0;
    end else begin
      state_q  <= state_d;
      chk_p_q  <= chk_p_d;
      kmax_q   <= kmax_d;
      k_q      <= k_d;
      d_q      <= d_d;
      inc_q    <= inc_d;
      r8_q     <= r8_d;
      found_q  <= found_d;
      err_q    <= err_d;
      factor_q <= factor_d;
      k_out_q  <= k_out_d;
      chk_d_q  <= chk_d_d;
    end
  end

`ifdef SMALL_PRIME_SIEVE_EN
  // small-prime residue registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
      pm3_q <= '0;
      pm5_q <= '0;
      pm7_q <= '0;
      i3_q  <= '0;
      i5_q  <= '0;
      i7_q  <= '0;
      r3_q  <= '0;
      r5_q  <= '0;
      r7_q  <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      pm3_q <= pm3_d;
      pm5_q <= pm5_d;
      pm7_q <= pm7_d;
      i3_q  <= i3_d;
      i5_q  <= i5_d;
      i7_q  <= i7_d;
      r3_q  <= r3_d;
      r5_q  <= r5_d;
      r7_q  <= r7_d;
    end
  end
`endif

  // status and strobes decode straight from the state register
  assign bus.busy      = (state_q == S_INIT) || (state_q == S_GEN) ||
                         (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bus.done      = (state_q == S_DONE);
  assign bus.chk_start = (state_q == S_ISSUE);
  assign bus.found     = found_q;
  assign bus.err       = err_q;
  assign bus.factor    = factor_q;
  assign bus.k_out     = k_out_q;
  assign bus.chk_p     = chk_p_q;
  assign bus.chk_d     = chk_d_q;

endmodule
`default_nettype wire

// File: tb/tb_mersenne_candidate_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mersenne_candidate_gen
//  Brief    : Scoreboard bench for the candidate generator with a behavioural
//             checker answering three cycles after each chk_start.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mersenne_candidate_gen;
  localparam int DW    = 32;
  localparam int KW    = 32;
  localparam int LIMIT = 5000;

  typedef struct {
    bit              found;
    bit              err;
    longint unsigned factor;
    longint unsigned kout;
  } res_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  res_t            exp_res_q[$];
  longint unsigned exp_issue_q[$];
  longint unsigned cur_p = 0;

  longint unsigned md;
  longint unsigned mexp;
  bit              mverdict;

  always #5 sys_clk = ~sys_clk;

  mersenne_candidate_gen_if #(.DW(DW), .KW(KW)) bus ();

  mersenne_candidate_gen #(.DW(DW), .KW(KW)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  task automatic check_eq(input string tag, input longint unsigned got,
                          input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // 2^p mod d == 1 means d divides 2^p - 1
  function automatic bit is_factor(input longint unsigned p, input longint unsigned d);
    longint unsigned r, b, e;
    r = 1;
    b = 2 % d;
    e = p;
    while (e != 0) begin
      if (e[0]) r = (r * b) % d;
      b = (b * b) % d;
      e = e >> 1;
    end
    return (r == 1);
  endfunction

  function automatic bit passes(input longint unsigned d);
    bit ok;
    ok = ((d % 8) == 1) || ((d % 8) == 7);
`ifdef SMALL_PRIME_SIEVE_EN
    if (((d % 3) == 0 && d != 3) || ((d % 5) == 0 && d != 5) || ((d % 7) == 0 && d != 7))
      ok = 1'b0;
`endif
    return ok;
  endfunction

  // reference walk: expected issues and final result for one search
  task automatic build_model(input longint unsigned p, input longint unsigned kmax);
    res_t r;
    longint unsigned k, d;
    bit stop;
    r.found = 0; r.err = 0; r.factor = 0; r.kout = 0;
    if (p < 3 || p[0] == 1'b0) begin
      r.err = 1;
    end else begin
      k = 1;
      stop = 0;
      while (!stop) begin
        d = 2 * k * p + 1;
        if (d > 64'hFFFF_FFFF) begin
          r.err = 1; r.kout = k - 1; stop = 1;
        end else if (k > kmax) begin
          r.kout = k - 1; stop = 1;
        end else begin
          if (passes(d)) begin
            exp_issue_q.push_back(d);
            if (is_factor(p, d)) begin
              r.found = 1; r.factor = d; r.kout = k; stop = 1;
            end
          end
          k++;
        end
      end
    end
    exp_res_q.push_back(r);
  endtask

  task automatic launch(input longint unsigned p, input longint unsigned kmax);
    build_model(p, kmax);
    cur_p = p;
    @(negedge sys_clk);
    bus.p     = p[DW-1:0];
    bus.k_max = kmax[KW-1:0];
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < LIMIT) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq("done_seen", bus.done, 1);
  endtask

  task automatic check_result();
    res_t r;
    check_eq("result_queue", exp_res_q.size(), 1);
    if (exp_res_q.size() > 0) begin
      r = exp_res_q.pop_front();
      check_eq("found",  bus.found,  r.found);
      check_eq("err",    bus.err,    r.err);
      check_eq("factor", bus.factor, r.factor);
      check_eq("k_out",  bus.k_out,  r.kout);
    end
    check_eq("busy_at_done", bus.busy, 0);
    check_eq("issues_left", exp_issue_q.size(), 0);
  endtask

  task automatic run_search(input longint unsigned p, input longint unsigned kmax);
    int n;
    launch(p, kmax);
    wait_done(n);
    check_result();
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_busy"},      bus.busy,      0);
    check_eq({pfx, "_done"},      bus.done,      0);
    check_eq({pfx, "_found"},     bus.found,     0);
    check_eq({pfx, "_err"},       bus.err,       0);
    check_eq({pfx, "_factor"},    bus.factor,    0);
    check_eq({pfx, "_k_out"},     bus.k_out,     0);
    check_eq({pfx, "_chk_start"}, bus.chk_start, 0);
    check_eq({pfx, "_chk_p"},     bus.chk_p,     0);
    check_eq({pfx, "_chk_d"},     bus.chk_d,     0);
  endtask

  // behavioural checker: compare each issue against the scoreboard, answer later
  initial begin
    bus.chk_finished = 1'b0;
    bus.chk_isPrime  = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (bus.chk_start === 1'b1) begin
        md = bus.chk_d;
        check_eq("issue_mod8_ok", ((md % 8) == 1) || ((md % 8) == 7), 1);
        check_eq("issue_expected", exp_issue_q.size() != 0, 1);
        if (exp_issue_q.size() != 0) begin
          mexp = exp_issue_q.pop_front();
          check_eq("issue_d", md, mexp);
        end
        check_eq("issue_p", bus.chk_p, cur_p);
        mverdict = !is_factor(cur_p, md);
        repeat (3) @(negedge sys_clk);
        bus.chk_isPrime  = mverdict;
        bus.chk_finished = 1'b1;
        @(negedge sys_clk);
        bus.chk_finished = 1'b0;
        bus.chk_isPrime  = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got time limit expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.start = 1'b0;
    bus.p     = '0;
    bus.k_max = '0;
    sys_rst   = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_reset_vals("rst");
    sys_rst = 1'b0;
    @(negedge sys_clk);

    run_search(11, 10);
    run_search(29, 10);

    // long search; a start while busy and a start in the DONE cycle are dropped
    launch(13, 100);
    repeat (20) @(negedge sys_clk);
    bus.p = 11; bus.k_max = 1; bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    check_eq("busy_after_ignored_start", bus.busy, 1);
    wait_done(n);
    check_result();
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    check_eq("start_in_done_ignored", bus.busy, 0);
    @(negedge sys_clk);
    check_eq("still_idle", bus.busy, 0);

    run_search(2147483647, 5);

    launch(4, 10);
    wait_done(n);
    check_eq("badp_latency", n + 1, 2);
    check_result();

    run_search(11, 0);

    // reset while waiting for a verdict, then a clean rerun
    launch(23, 10);
    n = 0;
    while (bus.chk_start !== 1'b1 && n < LIMIT) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq("issue_seen", bus.chk_start, 1);
    @(negedge sys_clk);
    check_eq("busy_in_wait", bus.busy, 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_reset_vals("midrst");
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (6) @(negedge sys_clk);
    check_eq("stale_verdict_found", bus.found, 0);
    check_eq("stale_verdict_busy",  bus.busy,  0);
    exp_res_q.delete();
    exp_issue_q.delete();
    run_search(23, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
